audio_echo_core: RTL

AUDIO_ECHO_CORE -- requirements
Module: audio_echo_core

---
 rtl/audio_echo_core.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/audio_echo_core.sv
// Multichannel echo core: one shared delay RAM addressed {ch, ptr}, a round-robin
// channel scheduler and a saturating wet/feedback mix, one sample in flight at a time.
module audio_echo_core #(
  parameter int DATA_W  = 16,
  parameter int NCH     = 2,
  parameter int DEPTH_W = 12,
  parameter int SHIFT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH*DATA_W-1:0] in_data,
  input  logic [NCH-1:0]        in_valid,
  output logic [NCH-1:0]        in_ready,
  output logic [NCH*DATA_W-1:0] out_data,
  output logic [NCH-1:0]        out_valid,
  input  logic [NCH-1:0]        out_ready,
  input  logic [DEPTH_W-1:0]    delay,
  input  logic [SHIFT_W-1:0]    wet_shift,
  input  logic [SHIFT_W-1:0]    fb_shift,
  input  logic                  fx_en,
  input  logic                  fb_en,
  input  logic                  mute,
  input  logic                  clr_flags,
  output logic [NCH-1:0]        sat_flag,
  output logic                  busy
);

  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW     = CH_W + DEPTH_W;
  localparam int NWORDS = NCH * (2 ** DEPTH_W);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(NWORDS - 1);
  localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NCH - 1);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; valid never depends on ready, and out_data is held while
  // out_valid is high and out_ready is low.

  typedef enum logic [2:0] {S_CLEAR, S_SCAN, S_READ, S_MIX, S_WRITE} state_t;
  state_t state, state_nxt;

  logic [CH_W-1:0]    ch_sel, ch_cur, ch_nxt;
  logic [DEPTH_W-1:0] wptr [NCH];
  logic [AW-1:0]      clr_addr, ra_q, ram_wa;
  logic [DATA_W-1:0]  mem [NWORDS];
  logic [DATA_W-1:0]  rd_q, x_q, y_q, w_q, ram_wd, y_mix, w_mix;
  logic               mute_q, ram_we, accept, clamp, ovf_y, ovf_w;
  logic [NCH-1:0]     sat_set;

  logic signed [DATA_W-1:0] x_s, d_s, wet_d, fb_d;
  logic signed [DATA_W:0]   sum_y, sum_w;

  function automatic logic [DATA_W-1:0] sat(input logic [DATA_W:0] s);
    if (s[DATA_W] != s[DATA_W-1])
      sat = s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      sat = s[DATA_W-1:0];
  endfunction

  assign ch_nxt = (ch_sel == LAST_CH) ? '0 : ch_sel + 1'b1;
  assign accept = (state == S_SCAN) && in_valid[ch_sel] && in_ready[ch_sel];
  assign busy   = (state != S_SCAN);

  always_comb begin
    in_ready = '0;
    for (int c = 0; c < NCH; c++)
      in_ready[c] = (state == S_SCAN) && (ch_sel == CH_W'(c)) && !out_valid[c];
  end

  // Sums carry one guard bit so overflow shows as a mismatch of the top two bits.
  assign x_s   = x_q;
  assign d_s   = rd_q;
  assign wet_d = d_s >>> wet_shift;
  assign fb_d  = d_s >>> fb_shift;
  assign sum_y = {x_s[DATA_W-1], x_s} + {wet_d[DATA_W-1], wet_d};
  assign sum_w = {x_s[DATA_W-1], x_s} + {fb_d[DATA_W-1], fb_d};
  assign ovf_y = sum_y[DATA_W] ^ sum_y[DATA_W-1];
  assign ovf_w = sum_w[DATA_W] ^ sum_w[DATA_W-1];

  always_comb begin
    y_mix = x_q;
    w_mix = x_q;
    clamp = 1'b0;
    if (fx_en) begin
      y_mix = sat(sum_y);
      clamp = ovf_y;
    end
    if (fx_en && fb_en) begin
      w_mix = sat(sum_w);
      clamp = clamp | ovf_w;
    end
  end

  always_comb begin
    sat_set = '0;
    if (state == S_MIX) sat_set[ch_cur] = clamp;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_CLEAR;
    else        state <= state_nxt;
  end

  // Writes are gated by rst_n so a sample caught by reset never reaches memory.
  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    ram_wa    = clr_addr;
    ram_wd    = '0;
    case (state)
      S_CLEAR: begin
        ram_we = rst_n;
        if (clr_addr == LAST_ADDR) state_nxt = S_SCAN;
      end
      S_SCAN:  if (accept) state_nxt = S_READ;
      S_READ:  state_nxt = S_MIX;
      S_MIX:   state_nxt = S_WRITE;
      S_WRITE: begin
        ram_we    = rst_n;
        ram_wa    = {ch_cur, wptr[ch_cur]};
        ram_wd    = w_q;
        state_nxt = S_SCAN;
      end
      default: state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_wd;
    rd_q <= mem[ra_q];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_addr  <= '0;
      ch_sel    <= '0;
      ch_cur    <= '0;
      ra_q      <= '0;
      out_valid <= '0;
      out_data  <= '0;
      sat_flag  <= '0;
      for (int c = 0; c < NCH; c++) wptr[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++)
        if (out_valid[c] && out_ready[c]) out_valid[c] <= 1'b0;
      sat_flag <= (sat_flag & ~{NCH{clr_flags}}) | sat_set;
      case (state)
        S_CLEAR: clr_addr <= clr_addr + 1'b1;
        S_SCAN: begin
          if (accept) begin
            x_q    <= in_data[int'(ch_sel)*DATA_W +: DATA_W];
            ch_cur <= ch_sel;
            ra_q   <= {ch_sel, wptr[ch_sel] - delay};
          end else begin
            ch_sel <= ch_nxt;
          end
        end
        S_MIX: begin
          y_q    <= y_mix;
          w_q    <= w_mix;
          mute_q <= mute;
        end
        S_WRITE: begin
          wptr[ch_cur] <= wptr[ch_cur] + 1'b1;
          out_data[int'(ch_cur)*DATA_W +: DATA_W] <= mute_q ? '0 : y_q;
          out_valid[ch_cur] <= 1'b1;
          ch_sel <= ch_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule
